// File: rtl/mux_n_pipe.sv
// ---------------------------------------------------------------------------
// mux_n_pipe
//   N-channel, W-bit registered multiplexer with valid/ready handshaking.
//   One of N producer streams is forwarded through a single output register
//   that supports full one-word-per-cycle throughput and backpressure.
//   Completed output transfers are counted in a free-running wrapping counter.
//
//   Build option:
//     MUX_RR_ARB_EN  - when defined, i_sel is ignored and a round-robin
//                      arbiter picks the channel. When undefined (default),
//                      the channel comes from i_sel, and an out-of-range
//                      select raises o_err_sel.
// ---------------------------------------------------------------------------
module mux_n_pipe #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = $clog2(N),
    parameter int CW   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N*W-1:0]    i_in_data,
    input  logic [N-1:0]      i_in_valid,
    output logic [N-1:0]      o_in_ready,
    input  logic [SELW-1:0]   i_sel,
    output logic [W-1:0]      o_out_data,
    output logic [SELW-1:0]   o_out_ch,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_err_sel,
    output logic [CW-1:0]     o_xfer_cnt
);

    // Output register stage and transfer counter
    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [SELW-1:0]   r_out_ch;
    logic [CW-1:0]     r_xfer_cnt;

    // Effective channel and handshake terms
    logic [SELW-1:0]   w_g;
    logic              w_g_ok;
    logic [W-1:0]      w_g_data;
    logic              w_load_ok;
    logic              w_xfer_in;
    logic              w_xfer_out;

    // The output register can accept a word when it is empty or is being
    // drained on this same edge; this is what gives back-to-back throughput.
    assign w_load_ok  = !r_out_valid || i_out_ready;
    assign w_xfer_out = r_out_valid && i_out_ready;

    // Only the effective channel may see ready, and only when it is a real
    // channel index and the output register can take a word.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_in_ready
            assign o_in_ready[gi] = w_load_ok && w_g_ok && (w_g == SELW'(gi));
        end
    endgenerate

    // An input transfer happens when the single ready channel is also valid.
    assign w_xfer_in = |(o_in_ready & i_in_valid);

    // Data mux for the effective channel
    always_comb begin
        w_g_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_g == SELW'(k)) begin
                w_g_data = i_in_data[k*W +: W];
            end
        end
    end

`ifdef MUX_RR_ARB_EN
    // ---------------- round-robin arbitration ----------------
    logic [SELW-1:0]   r_ptr;
    logic              w_unused_sel;

    // The select input has no role when the arbiter chooses the channel.
    assign w_unused_sel = ^i_sel;

    // Grant the first valid channel at or after the pointer, wrapping modulo N.
    // Offsets are scanned from farthest to nearest so the nearest one wins.
    always_comb begin
        int idx;
        idx    = 0;
        w_g    = '0;
        w_g_ok = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(r_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (i_in_valid[idx[SELW-1:0]]) begin
                w_g    = idx[SELW-1:0];
                w_g_ok = 1'b1;
            end
        end
    end

    // Advance the pointer past the granted channel only on an accepted word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer_in) begin
            r_ptr <= (w_g == SELW'(N - 1)) ? '0 : w_g + 1'b1;
        end
    end

    // A select error cannot occur without a select input
    assign o_err_sel = 1'b0;
`else
    // ---------------- static select ----------------
    logic              r_err_sel;

    assign w_g = i_sel;

    // When N is a power of two every select code is a valid channel, so the
    // range check only exists for other channel counts.
    generate
        if ((1 << SELW) == N) begin : g_sel_full
            assign w_g_ok = 1'b1;
        end else begin : g_sel_chk
            assign w_g_ok = ({1'b0, i_sel} < (SELW + 1)'(N));
        end
    endgenerate

    // Flag an out-of-range select one cycle later, but only if some producer
    // was actually waiting; an idle bad select is harmless.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_sel <= 1'b0;
        end else begin
            r_err_sel <= !w_g_ok && (|i_in_valid);
        end
    end

    assign o_err_sel = r_err_sel;
`endif

    // Output register: load on input transfer, clear valid when drained
    // without a replacement, otherwise hold (stall or idle).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_g_data;
            r_out_ch    <= w_g;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count completed output transfers; wraps naturally at 2^CW
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer_out) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_xfer_cnt  = r_xfer_cnt;

endmodule
